si_tx_arbiter: RTL and testbench
================================

SI_TX_ARBITER -- requirements
Module: si_tx_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256, consecutive idle-source cycles before a granted packet is aborted (>=2).
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_data  input  8*N_SRC  byte of source i in bits [8i+7:8i].
REQ-006 SHALL have port req_rdy  input  N_SRC  source i has a valid byte.
REQ-007 SHALL have port req_last  input  N_SRC  source i's current byte ends its packet.
REQ-008 SHALL have port req_ack  output  N_SRC  source i's byte consumed this cycle.
REQ-009 SHALL have port tx_data_si  output  8  byte to the FT245 simple-interface TX side.
REQ-010 SHALL have port tx_rdy_si  output  1  byte valid to FT245 interface.
REQ-011 SHALL have port tx_ack_si  input  1  FT245 interface accepted tx_data_si this cycle; may depend combinationally on tx_rdy_si.
REQ-012 SHALL have port grant_id  output  $clog2(N_SRC)  index of current/last granted source.
REQ-013 SHALL have port busy  output  1  high while in ST_GRANT.
REQ-014 SHALL have port abort  output  1  one-cycle pulse when a packet is aborted by timeout.

Function
REQ-015 SHALL implement states ST_IDLE and ST_GRANT.
REQ-016 In ST_IDLE, tx_rdy_si and all req_ack SHALL be 0.
REQ-017 In ST_IDLE with any req_rdy high, SHALL select the first source with req_rdy high searching from last_grant+1 upward, wrapping N_SRC-1 -> 0, register it into grant_id, and enter ST_GRANT next cycle.
REQ-018 In ST_GRANT, tx_data_si SHALL equal req_data of grant_id and tx_rdy_si SHALL equal req_rdy[grant_id], combinationally.
REQ-019 In ST_GRANT, req_ack[grant_id] SHALL equal tx_ack_si & tx_rdy_si; all other req_ack SHALL be 0.
REQ-020 Latency from req_rdy rising in ST_IDLE to tx_rdy_si high SHALL be exactly 1 cycle.
REQ-021 Grant SHALL be held for the whole packet: ST_GRANT exits to ST_IDLE only on a cycle with tx_ack_si & tx_rdy_si & req_last[grant_id], or on timeout.
REQ-022 On packet end, last_grant SHALL be set to grant_id; the next arbitration occurs in the following ST_IDLE cycle (one idle cycle between packets, minimum).
REQ-023 Requests from non-granted sources SHALL be ignored until ST_IDLE, regardless of priority.
REQ-024 A timeout counter SHALL clear on entry to ST_GRANT and on any cycle with req_rdy[grant_id] high, and increment on each ST_GRANT cycle with req_rdy[grant_id] low.
REQ-025 Cycles with tx_rdy_si high but tx_ack_si low (FT245 back-pressure) SHALL NOT advance the timeout.
REQ-026 When the counter reaches TIMEOUT_CYC-1 with req_rdy[grant_id] still low, SHALL pulse abort for one cycle, set last_grant to grant_id, and return to ST_IDLE.
REQ-027 Counter width SHALL be $clog2(TIMEOUT_CYC) bits; it SHALL not wrap before timeout.
REQ-028 tx_data_si SHALL be 8'd0 in ST_IDLE.
REQ-029 grant_id SHALL retain its value in ST_IDLE until the next arbitration.

Reset
REQ-030 rst high SHALL asynchronously force state ST_IDLE, last_grant N_SRC-1 (source 0 wins first), grant_id 0, timeout counter 0, abort 0, busy 0.
REQ-031 Reset asserted mid-packet SHALL drop tx_rdy_si and all req_ack immediately; no partial packet resumes after release.
REQ-032 First arbitration SHALL occur on the first rising clk edge after rst deasserts.

Verification
REQ-033 Single source: after reset, src0 sends 3 bytes 0xA1,0xA2,0xA3 (last on 0xA3), tx_ack_si always 1 -> tx_rdy_si high 1 cycle after req_rdy, 3 acks, busy drops, grant_id=0.
REQ-034 Round robin: all 4 sources hold 1-byte packets continuously -> grant order 0,1,2,3,0, each separated by one ST_IDLE cycle.
REQ-035 Packet lock: src1 granted on 4-byte packet, src0 asserts req_rdy after byte 1 -> src0 gets no req_ack until src1's last byte acked; next grant is src2 or src3 if requesting, else src0.
REQ-036 Back-pressure: src2 granted, tx_ack_si held 0 for 1000 cycles with req_rdy[2]=1, TIMEOUT_CYC=256 -> no abort, byte delivered when tx_ack_si returns.
REQ-037 Timeout: src3 sends 1 non-last byte then drops req_rdy, TIMEOUT_CYC=256 -> abort pulses exactly once, 256 cycles after req_rdy falls, then ST_IDLE; next arbitration starts at src0.
REQ-038 Reset mid-packet: assert rst during byte 2 of a src1 packet -> tx_rdy_si=0 same cycle, after release src0 wins first arbitration.

Source files
------------

// File: rtl/si_tx_arbiter.sv
// Round-robin packet arbiter: merges N_SRC byte streams onto one FT245
// simple-interface TX port, holding each grant for a whole packet and
// aborting a packet whose source stays idle for TIMEOUT_CYC cycles.
module si_tx_arbiter #(
   parameter int unsigned N_SRC       = 4,
   parameter int unsigned TIMEOUT_CYC = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [8*N_SRC-1:0]         req_data,
   input  logic [N_SRC-1:0]           req_rdy,
   input  logic [N_SRC-1:0]           req_last,
   output logic [N_SRC-1:0]           req_ack,
   output logic [7:0]                 tx_data_si,
   output logic                       tx_rdy_si,
   input  logic                       tx_ack_si,
   output logic [$clog2(N_SRC)-1:0]   grant_id,
   output logic                       busy,
   output logic                       abort
);

   localparam int unsigned GW = $clog2(N_SRC);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_grant_id;
   logic [GW-1:0]   r_last_grant;
   logic [TW-1:0]   r_tmo_cnt;
   logic            r_busy;
   logic            r_abort;

   logic [GW-1:0]   w_pick;
   logic [GW-1:0]   w_idx;
   logic            w_src_rdy;
   logic            w_src_last;
   logic            w_xfer;
   logic            w_tmo_hit;

   // Round-robin search: walk offsets downward so the nearest requester after last_grant wins
   always_comb begin
      w_pick = r_last_grant;
      w_idx  = '0;
      for (int unsigned k = N_SRC; k > 0; k--) begin
         w_idx = GW'((32'(r_last_grant) + 32'(k)) % N_SRC);
         if (req_rdy[w_idx]) begin
            w_pick = w_idx;
         end
      end
   end

   assign w_src_rdy  = req_rdy[r_grant_id];
   assign w_src_last = req_last[r_grant_id];
   assign w_xfer     = (r_state == ST_GRANT) && w_src_rdy && tx_ack_si;
   assign w_tmo_hit  = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

   // Data path: route the granted source straight through to the TX side
   always_comb begin
      tx_data_si = 8'd0;
      tx_rdy_si  = 1'b0;
      req_ack    = '0;
      if (r_state == ST_GRANT) begin
         tx_data_si          = req_data[32'(r_grant_id)*8 +: 8];
         tx_rdy_si           = w_src_rdy;
         req_ack[r_grant_id] = w_src_rdy & tx_ack_si;
      end
   end

   // Arbitration FSM with packet lock and idle-source timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= GW'(N_SRC - 1);
         r_grant_id   <= '0;
         r_tmo_cnt    <= '0;
         r_busy       <= 1'b0;
         r_abort      <= 1'b0;
      end else begin
         r_abort <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|req_rdy) begin
                  r_grant_id <= w_pick;
                  r_tmo_cnt  <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_xfer && w_src_last) begin
                  r_last_grant <= r_grant_id;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end else if (w_src_rdy) begin
                  // Source is presenting data (even if back-pressured): not idle
                  r_tmo_cnt <= '0;
               end else if (w_tmo_hit) begin
                  r_abort      <= 1'b1;
                  r_last_grant <= r_grant_id;
                  r_tmo_cnt    <= '0;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant_id = r_grant_id;
   assign busy     = r_busy;
   assign abort    = r_abort;

endmodule

// File: tb/tb_si_tx_arbiter.sv
// Bench for si_tx_arbiter: directed scenarios plus random traffic, every
// cycle compared against a packet-level reference model.
module tb_si_tx_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned GW  = 2;
   localparam int unsigned TMO = 256;

   logic             clk;
   logic             rst;
   logic [8*N-1:0]   req_data;
   logic [N-1:0]     req_rdy;
   logic [N-1:0]     req_last;
   logic [N-1:0]     req_ack;
   logic [7:0]       tx_data_si;
   logic             tx_rdy_si;
   logic             tx_ack_si;
   logic [GW-1:0]    grant_id;
   logic             busy;
   logic             abort;

   si_tx_arbiter #(.N_SRC(N), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_data   (req_data),
      .req_rdy    (req_rdy),
      .req_last   (req_last),
      .req_ack    (req_ack),
      .tx_data_si (tx_data_si),
      .tx_rdy_si  (tx_rdy_si),
      .tx_ack_si  (tx_ack_si),
      .grant_id   (grant_id),
      .busy       (busy),
      .abort      (abort)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Reference model: who owns the port (-1 = nobody), whose packet ended last,
   // and how long the owner has been silent.
   int           m_gnt;
   int           m_last;
   int           m_gid;
   int           m_quiet;
   bit           m_abort;
   logic [N-1:0] m_acked;

   // Observations
   int ack_cnt [N];
   int abort_cnt;
   int grant_q [$];
   int ack_cyc_q [$];
   int cyc;

   // Random source state
   int         s_left [N];
   bit         s_on   [N];
   logic [7:0] s_seq  [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic bit_of(input logic [N-1:0] v, input int i);
      return v[GW'(i)];
   endfunction

   function automatic logic [7:0] byte_of(input logic [8*N-1:0] v, input int i);
      return v[8*i +: 8];
   endfunction

   task automatic model_reset();
      m_gnt   = -1;
      m_last  = N - 1;
      m_gid   = 0;
      m_quiet = 0;
      m_abort = 0;
      m_acked = '0;
   endtask

   // One clock edge of the reference behaviour
   task automatic model_edge();
      int  g;
      int  cand;
      bit  found;
      m_acked = '0;
      m_abort = 0;
      if (m_gnt < 0) begin
         found = 0;
         for (int k = 1; k <= int'(N); k++) begin
            cand = (m_last + k) % N;
            if (!found && bit_of(req_rdy, cand)) begin
               m_gnt = cand;
               found = 1;
            end
         end
         if (found) begin
            m_gid   = m_gnt;
            m_quiet = 0;
         end
      end else begin
         g = m_gnt;
         if (bit_of(req_rdy, g)) begin
            m_quiet = 0;
            if (tx_ack_si) begin
               m_acked[GW'(g)] = 1'b1;
               if (bit_of(req_last, g)) begin
                  m_last = g;
                  m_gnt  = -1;
               end
            end
         end else begin
            m_quiet++;
            if (m_quiet == int'(TMO)) begin
               m_abort = 1;
               m_last  = g;
               m_gnt   = -1;
            end
         end
      end
   endtask

   task automatic check_cycle();
      logic [N-1:0] e_ack;
      logic [7:0]   e_data;
      logic         e_rdy;
      e_ack  = '0;
      e_data = 8'd0;
      e_rdy  = 1'b0;
      if (m_gnt >= 0) begin
         e_rdy  = bit_of(req_rdy, m_gnt);
         e_data = byte_of(req_data, m_gnt);
         if (e_rdy && tx_ack_si) e_ack[GW'(m_gnt)] = 1'b1;
      end
      chk("tx_rdy_si",  32'(tx_rdy_si),  32'(e_rdy));
      chk("tx_data_si", 32'(tx_data_si), 32'(e_data));
      chk("req_ack",    32'(req_ack),    32'(e_ack));
      chk("busy",       32'(busy),       32'(m_gnt >= 0));
      chk("grant_id",   32'(grant_id),   32'(m_gid));
      chk("abort",      32'(abort),      32'(m_abort));
      for (int i = 0; i < int'(N); i++) begin
         if (bit_of(req_ack, i)) begin
            ack_cnt[i]++;
            grant_q.push_back(i);
            ack_cyc_q.push_back(cyc);
         end
      end
      if (abort) abort_cnt++;
   endtask

   // Check mid-cycle, then advance model across the rising edge
   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      cyc++;
      #1;
   endtask

   task automatic clear_obs();
      for (int i = 0; i < int'(N); i++) ack_cnt[i] = 0;
      abort_cnt = 0;
      grant_q.delete();
      ack_cyc_q.delete();
   endtask

   task automatic set_src(input int i, input logic rdy, input logic [7:0] d, input logic last);
      req_rdy[GW'(i)]   = rdy;
      req_last[GW'(i)]  = last;
      req_data[8*i +: 8] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic rand_drive();
      for (int i = 0; i < int'(N); i++) begin
         if (m_acked[GW'(i)] && s_left[i] > 0) begin
            s_left[i]--;
            s_seq[i] = s_seq[i] + 8'd1;
         end
         if (s_left[i] == 0) begin
            s_on[i] = 0;
            if ($urandom_range(3) == 0) begin
               s_left[i] = int'($urandom_range(4, 1));
               s_on[i]   = 1;
            end
         end else if (!s_on[i]) begin
            if ($urandom_range(1) == 0) s_on[i] = 1;
         end else if ($urandom_range(9) == 0) begin
            s_on[i] = 0;
         end
         set_src(i, s_on[i], {2'(i), s_seq[i][5:0]}, s_left[i] == 1);
      end
      tx_ack_si = ($urandom_range(3) != 0);
   endtask

   initial begin
      int rr_exp [5];
      int first_abort;
      rr_exp = '{0, 1, 2, 3, 0};
      cyc = 0;
      req_data  = '0;
      req_rdy   = '0;
      req_last  = '0;
      tx_ack_si = 1'b0;
      rst       = 1'b1;
      model_reset();
      clear_obs();
      #1;
      // Reset state
      chk("rst_busy",     32'(busy),      32'd0);
      chk("rst_grant_id", 32'(grant_id),  32'd0);
      chk("rst_abort",    32'(abort),     32'd0);
      chk("rst_tx_rdy",   32'(tx_rdy_si), 32'd0);
      do_reset();

      // Single source, three bytes, ack always high
      tx_ack_si = 1'b1;
      set_src(0, 1'b1, 8'hA1, 1'b0);
      tick();
      chk("single_latency_rdy", 32'(tx_rdy_si), 32'd1);
      chk("single_busy",        32'(busy),      32'd1);
      tick();
      set_src(0, 1'b1, 8'hA2, 1'b0);
      tick();
      set_src(0, 1'b1, 8'hA3, 1'b1);
      tick();
      set_src(0, 1'b0, 8'h00, 1'b0);
      chk("single_acks",     32'(ack_cnt[0]), 32'd3);
      chk("single_busy_end", 32'(busy),       32'd0);
      chk("single_gid",      32'(grant_id),   32'd0);
      tick();

      // Round robin with continuous one-byte packets
      for (int i = 0; i < int'(N); i++) set_src(i, 1'b1, 8'(8'h40 + i), 1'b1);
      do_reset();
      clear_obs();
      repeat (10) tick();
      req_rdy  = '0;
      req_last = '0;
      chk("rr_count", 32'(grant_q.size()), 32'd5);
      for (int k = 0; k < 5 && k < grant_q.size(); k++) begin
         chk("rr_order", 32'(grant_q[k]), 32'(rr_exp[k]));
         if (k > 0) chk("rr_gap", 32'(ack_cyc_q[k] - ack_cyc_q[k-1]), 32'd2);
      end
      tick();

      // Packet lock: src0 and src2 request mid-packet of src1
      clear_obs();
      set_src(1, 1'b1, 8'h11, 1'b0);
      tick();
      tick();
      set_src(0, 1'b1, 8'h50, 1'b1);
      set_src(2, 1'b1, 8'h52, 1'b1);
      set_src(1, 1'b1, 8'h12, 1'b0);
      tick();
      set_src(1, 1'b1, 8'h13, 1'b0);
      tick();
      set_src(1, 1'b1, 8'h14, 1'b1);
      tick();
      chk("lock_src1_acks", 32'(ack_cnt[1]), 32'd4);
      chk("lock_src0_acks", 32'(ack_cnt[0]), 32'd0);
      chk("lock_idle",      32'(busy),       32'd0);
      set_src(1, 1'b0, 8'h00, 1'b0);
      tick();
      chk("lock_next_src2", 32'(grant_id), 32'd2);
      tick();
      set_src(2, 1'b0, 8'h00, 1'b0);
      tick();
      chk("lock_then_src0", 32'(grant_id), 32'd0);
      tick();
      set_src(0, 1'b0, 8'h00, 1'b0);
      tick();

      // Back-pressure far beyond the timeout must not abort
      clear_obs();
      tx_ack_si = 1'b0;
      set_src(2, 1'b1, 8'h2B, 1'b1);
      tick();
      repeat (1000) tick();
      chk("bp_no_abort", 32'(abort_cnt), 32'd0);
      chk("bp_busy",     32'(busy),      32'd1);
      chk("bp_gid",      32'(grant_id),  32'd2);
      tx_ack_si = 1'b1;
      tick();
      chk("bp_delivered", 32'(ack_cnt[2]), 32'd1);
      chk("bp_done",      32'(busy),       32'd0);
      set_src(2, 1'b0, 8'h00, 1'b0);
      tick();

      // Timeout: src3 stalls after one non-last byte
      set_src(3, 1'b1, 8'h3C, 1'b0);
      tick();
      tick();
      set_src(3, 1'b0, 8'h00, 1'b0);
      clear_obs();
      first_abort = -1;
      for (int n = 1; n <= 300; n++) begin
         tick();
         if (abort && first_abort < 0) first_abort = n;
      end
      chk("tmo_latency", 32'(first_abort), 32'd256);
      chk("tmo_once",    32'(abort_cnt),   32'd1);
      chk("tmo_idle",    32'(busy),        32'd0);
      set_src(0, 1'b1, 8'h01, 1'b1);
      set_src(1, 1'b1, 8'h02, 1'b1);
      tick();
      chk("tmo_next_src0", 32'(grant_id), 32'd0);
      tick();
      set_src(0, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      set_src(1, 1'b0, 8'h00, 1'b0);
      tick();

      // Reset in the middle of a src1 packet
      set_src(1, 1'b1, 8'h61, 1'b0);
      tick();
      tick();
      set_src(1, 1'b1, 8'h62, 1'b0);
      set_src(0, 1'b1, 8'h70, 1'b1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("midrst_tx_rdy", 32'(tx_rdy_si), 32'd0);
      chk("midrst_ack",    32'(req_ack),   32'd0);
      chk("midrst_busy",   32'(busy),      32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("midrst_src0_first", 32'(grant_id), 32'd0);
      tick();
      set_src(0, 1'b0, 8'h00, 1'b0);
      set_src(1, 1'b0, 8'h00, 1'b0);
      tick();

      // Random traffic against the model
      for (int i = 0; i < int'(N); i++) begin
         s_left[i] = 0;
         s_on[i]   = 0;
         s_seq[i]  = 8'd0;
      end
      m_acked = '0;
      repeat (3000) begin
         rand_drive();
         tick();
      end
      req_rdy   = '0;
      req_last  = '0;
      tx_ack_si = 1'b0;
      repeat (4) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
